// File: rtl/load_use_scoreboard.sv
// Producer-side hazard scoreboard for the 5-stage pipeline.
// Each architectural register has a countdown. It holds the number of cycles
// left before that register's pending result can be forwarded into EX. A
// consumer in ID is stalled while any register it reads still has a nonzero
// countdown.
module load_use_scoreboard #(
   parameter int unsigned MUL_LAT = 3,
   parameter int unsigned CNT_W   = 3,
   parameter int unsigned STAT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [4:0]        id_rs,
   input  logic [4:0]        id_rt,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic              id_reg_write,
   input  logic [4:0]        id_rd,
   input  logic [1:0]        id_lat_class,
   output logic              stall,
   output logic [31:0]       pending_mask,
   output logic [STAT_W-1:0] stall_cycles
);

   localparam int unsigned NREG = 32;

   localparam logic [1:0] CLS_ALU  = 2'b00;
   localparam logic [1:0] CLS_LOAD = 2'b01;
   localparam logic [1:0] CLS_MUL  = 2'b10;

   localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(1);
   localparam logic [CNT_W-1:0] MUL_CNT  = CNT_W'(MUL_LAT);

   // Per-register countdowns. Entry 0 is never loaded, so it stays 0.
   logic [CNT_W-1:0] cnt [NREG];

   logic             rs_busy;
   logic             rt_busy;
   logic             issue;
   logic             record;
   logic [CNT_W-1:0] load_val;

   // Hazard detection against the pre-update counters.
   // A producer that reads its own destination therefore never stalls on itself.
   always_comb begin
      rs_busy = 1'b0;
      rt_busy = 1'b0;
      if (id_uses_rs) rs_busy = (cnt[id_rs] != '0);
      if (id_uses_rt) rt_busy = (cnt[id_rt] != '0);
      stall  = id_valid && (rs_busy || rt_busy);
      issue  = id_valid && !stall;
      record = issue && id_reg_write && (id_rd != 5'd0);
   end

   // Forwarding distance of the issuing producer; class 11 behaves like a load.
   always_comb begin
      load_val = LOAD_CNT;
      case (id_lat_class)
         CLS_ALU:  load_val = '0;
         CLS_LOAD: load_val = LOAD_CNT;
         CLS_MUL:  load_val = MUL_CNT;
         default:  load_val = LOAD_CNT;
      endcase
   end

   // Pending view of the scoreboard for debug and the ID stage.
   always_comb begin
      pending_mask = '0;
      for (int r = 0; r < NREG; r++) begin
         pending_mask[r] = (cnt[r] != '0);
      end
   end

   // Countdown update: a new producer overrides the entry (newest wins), otherwise it counts down to 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREG; r++) begin
            cnt[r] <= '0;
         end
      end else begin
         for (int r = 0; r < NREG; r++) begin
            if (record && (id_rd == 5'(r))) begin
               cnt[r] <= load_val;
            end else if (cnt[r] != '0) begin
               cnt[r] <= cnt[r] - CNT_W'(1);
            end
         end
      end
   end

   // Saturating count of cycles spent stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
      end else if (stall && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + STAT_W'(1);
      end
   end

endmodule

// File: doc/load_use_scoreboard.md
# load_use_scoreboard

Per-register hazard scoreboard for the 5-stage MIPS pipeline; it is the producer-side counterpart to the EX-stage forwarding logic. It records every register write issued from ID and counts down the cycles until that result can be forwarded. It then tells ID to stall any consumer that would reach EX before its operand is forwardable: one bubble after a load, MUL_LAT bubbles after a multi-cycle multiply. Sits beside the ID stage and drives the IF/ID and PC hold and the ID/EX bubble insertion.

## Interface
- MUL_LAT, 3: stall cycles required after a multiply issues (1..7).
- CNT_W, 3: width of each per-register countdown; must hold MUL_LAT.
- STAT_W, 16: width of the stall-cycle statistics counter.

- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- id_valid  in  1  a real instruction occupies ID this cycle.
- id_rs  in  5  source register rs of the ID instruction.
- id_rt  in  5  source register rt of the ID instruction.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_reg_write  in  1  ID instruction writes a register.
- id_rd  in  5  destination register, already muxed rd/rt/$ra.
- id_lat_class  in  2  00 ALU, 01 load, 10 multiply, 11 treated as load.
- stall  out  1  hold PC and IF/ID; inject a bubble into ID/EX.
- pending_mask  out  32  bit r is 1 while cnt[r] != 0.
- stall_cycles  out  STAT_W  saturating count of stalled cycles.

## Operation
- State: 32 countdowns cnt[0..31], each CNT_W bits, plus stall_cycles. cnt[0] is constant 0.
- Hazard condition, combinational: stall = id_valid && ((id_uses_rs && cnt[id_rs] != 0) || (id_uses_rt && cnt[id_rt] != 0)).
- issue = id_valid && !stall.
- Per-cycle update on every rising clk, for each r:
  - If issue && id_reg_write && id_rd == r && r != 0, then cnt[r] <= load value.
    - Load value: 0 for ALU, 1 for load or class 11, MUL_LAT for multiply.
  - Else if cnt[r] != 0, then cnt[r] <= cnt[r] - 1.
  - Else hold 0.
- A new issue to the same register overrides the in-progress countdown: WAW, the newest producer wins. This applies even when the new value is smaller, e.g. an ALU write after a multiply clears the entry.
- An ALU producer loads 0. EX/MEM forwarding covers it, so it never creates a stall.
- Writes to $0 are never recorded. Reads of $0 never stall.
- A stalled instruction does not issue, so its destination is not recorded until the cycle it actually issues.
- A producer may read its own destination, e.g. lw $t0,0($t0). The stall check uses pre-update counters, so an instruction never stalls on itself.
- stall_cycles increments when stall = 1 and holds at all-ones (saturates).
- pending_mask is derived combinationally from the counters.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): all cnt = 0, stall_cycles = 0, pending_mask = 0. Consequently stall = 0.
- Reset asserted mid-countdown: all entries clear immediately, with no clock needed. The first instruction after release never stalls.
- stall has zero latency from the ID inputs. Counter changes become visible to stall in the cycle after the issuing edge.
- Load issued in cycle t:
  - cnt = 1 during t+1, so a dependent instruction in ID stalls exactly 1 cycle.
  - The dependent issues in t+2; the load is then in WB and forwarding picks it up.
- Multiply issued in cycle t: a dependent stalls during t+1..t+MUL_LAT and issues in t+MUL_LAT+1.
- A dependent arriving later than t+1 stalls only for the remaining count; a load consumed at t+2 or later does not stall.
- Simultaneous issue to rd and decrement of cnt[rd]: issue value is written; there is no decrement that cycle.
- id_valid = 0: stall = 0; counters keep decrementing. Bubbles from fetch consume hazard time.

## Test plan
- Reset: drive rst_n=0 mid-multiply countdown (cnt[9]=2). Required: pending_mask=0 and stall=0 at once, with no clock edge; stall_cycles=0.
- Load-use: lw $8 in t, then add $10,$8,$9 in ID. Required: stall=1 in t+1 only, issue in t+2, stall_cycles=1.
- Multiply: mult producing $12 with MUL_LAT=3, then a consumer of $12. Required: stall in t+1..t+3, issue in t+4, stall_cycles=3.
- No-stall cases, all required to give stall=0 throughout:
  - add $8 followed by a consumer of $8;
  - lw $0 followed by a consumer of $0;
  - lw $8 followed by an instruction with id_uses_rs=id_uses_rt=0 but id_rs=8.
- WAW override: mult $8 in t, add $8 in t+1, consumer of $8 in t+2. Required: cnt[8]=0 after t+1 and no stall in t+2.
- Saturation: STAT_W=4, hold a 20-cycle stall by re-issuing multiplies. Required: stall_cycles stops at 15 and stays there.
